fpu_add_arbiter: RTL



---
 rtl/fpu_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 30 +++
 rtl/fpu_add_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU adder arbiter.
// Build option: FPU_ARB_WDOG_EN adds a WAIT-state watchdog (see fpu_add_arbiter).
package fpu_arb_pkg;

  // Arbiter FSM states, also exported on the debug port
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DELIVER = 3'd4
  } arb_state_t;

  // Quiet NaN returned when the watchdog abandons an operation
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int DEFAULT_NUM_REQ     = 4;
  localparam int DEFAULT_WDOG_CYCLES = 512;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request bit at or
// above i_ptr, wrapping around to bit 0.
module rr_picker #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Scan from the pointer upward, modulo N, taking the first hit
  always_comb begin : pick
    logic w_found;
    int   j;
    o_valid = |i_req;
    o_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[j]) begin
        o_idx   = IW'(j);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one non-pipelined FPU adder between NUM_REQ
// requesters. One operation in flight; result returned on the owner's channel.
//
// Handshake rule on every STB/BUSY channel: a transfer happens on a rising
// clock edge where the sender's STB is high and the receiver's BUSY is low.
//
// Build option FPU_ARB_WDOG_EN: WAIT is bounded by WDOG_CYCLES; on expiry a
// qNaN is delivered, wdog_err sets (sticky) and the late adder result is
// later consumed and dropped before the adder is used again.
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
`ifdef FPU_ARB_WDOG_EN
  , parameter int WDOG_CYCLES = DEFAULT_WDOG_CYCLES
`endif
  , localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_STB,
  output logic [NUM_REQ-1:0]    req_BUSY,
  output logic [31:0]           resp_sum,
  output logic [NUM_REQ-1:0]    resp_STB,
  input  logic [NUM_REQ-1:0]    resp_module_BUSY,
  output logic [31:0]           fpu_input_a,
  output logic [31:0]           fpu_input_b,
  output logic                  fpu_input_STB,
  input  logic                  fpu_BUSY,
  input  logic [31:0]           fpu_output_sum,
  input  logic                  fpu_output_STB,
  output logic                  fpu_output_module_BUSY,
`ifdef FPU_ARB_WDOG_EN
  output logic                  wdog_err,
`endif
  output arb_state_t            dbg_state
);

  arb_state_t         r_state, w_state_nxt;
  logic [IDW-1:0]     r_grant, w_grant_nxt;
  logic [IDW-1:0]     r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_req_busy, w_req_busy_nxt;
  logic [NUM_REQ-1:0] r_resp_stb, w_resp_stb_nxt;
  logic               r_fin_stb, w_fin_stb_nxt;
  logic               r_fout_busy, w_fout_busy_nxt;
  logic [31:0]        r_op_a, r_op_b, r_sum;
  logic [31:0]        w_sum_src;
  logic               w_op_load, w_sum_load;
  logic               w_pick_valid;
  logic [IDW-1:0]     w_pick_idx;

`ifdef FPU_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic           r_stale, w_stale_nxt;
  logic           r_wdog_err, w_wdog_err_nxt;
  logic [WCW-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
  assign wdog_err = r_wdog_err;
`endif

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req   (req_STB),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign req_BUSY               = r_req_busy;
  assign resp_STB               = r_resp_stb;
  assign resp_sum               = r_sum;
  assign fpu_input_a            = r_op_a;
  assign fpu_input_b            = r_op_b;
  assign fpu_input_STB          = r_fin_stb;
  assign fpu_output_module_BUSY = r_fout_busy;
  assign dbg_state              = r_state;

  // Next-state and next-output decode; every target defaults to hold
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_req_busy_nxt  = r_req_busy;
    w_resp_stb_nxt  = r_resp_stb;
    w_fin_stb_nxt   = r_fin_stb;
    w_fout_busy_nxt = r_fout_busy;
    w_op_load       = 1'b0;
    w_sum_load      = 1'b0;
    w_sum_src       = fpu_output_sum;
`ifdef FPU_ARB_WDOG_EN
    w_stale_nxt     = r_stale;
    w_wdog_err_nxt  = r_wdog_err;
    w_wdog_cnt_nxt  = r_wdog_cnt;
    // Outside WAIT a stale result is swallowed; the channel then closes again
    if (r_state != S_WAIT && r_stale && fpu_output_STB && !r_fout_busy) begin
      w_stale_nxt     = 1'b0;
      w_fout_busy_nxt = 1'b1;
    end
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt                = w_pick_idx;
          w_req_busy_nxt[w_pick_idx] = 1'b0;
          w_state_nxt                = S_GRANT;
        end
      end
      S_GRANT: begin
        // The winner holds STB, so its transfer completes on this edge
        w_op_load      = 1'b1;
        w_req_busy_nxt = '1;
`ifdef FPU_ARB_WDOG_EN
        w_fin_stb_nxt  = !w_stale_nxt;
`else
        w_fin_stb_nxt  = 1'b1;
`endif
        w_state_nxt    = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_fin_stb && !fpu_BUSY) begin
          w_fin_stb_nxt   = 1'b0;
          w_fout_busy_nxt = 1'b0;
          w_state_nxt     = S_WAIT;
`ifdef FPU_ARB_WDOG_EN
          w_wdog_cnt_nxt  = '0;
        end else if (!w_stale_nxt) begin
          w_fin_stb_nxt   = 1'b1;
`endif
        end
      end
      S_WAIT: begin
        if (fpu_output_STB && !r_fout_busy) begin
          w_sum_load               = 1'b1;
          w_fout_busy_nxt          = 1'b1;
          w_resp_stb_nxt[r_grant]  = 1'b1;
          w_state_nxt              = S_DELIVER;
`ifdef FPU_ARB_WDOG_EN
        end else if (r_wdog_cnt == WCW'(WDOG_CYCLES - 1)) begin
          // Give up: return qNaN, leave the result channel open for the discard
          w_sum_src                = QNAN;
          w_sum_load               = 1'b1;
          w_wdog_err_nxt           = 1'b1;
          w_stale_nxt              = 1'b1;
          w_resp_stb_nxt[r_grant]  = 1'b1;
          w_state_nxt              = S_DELIVER;
        end else begin
          w_wdog_cnt_nxt           = r_wdog_cnt + 1'b1;
`endif
        end
      end
      S_DELIVER: begin
        if (r_resp_stb[r_grant] && !resp_module_BUSY[r_grant]) begin
          w_resp_stb_nxt = '0;
          w_ptr_nxt      = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_req_busy  <= '1;
      r_resp_stb  <= '0;
      r_fin_stb   <= 1'b0;
      r_fout_busy <= 1'b1;
`ifdef FPU_ARB_WDOG_EN
      r_stale     <= 1'b0;
      r_wdog_err  <= 1'b0;
      r_wdog_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_req_busy  <= w_req_busy_nxt;
      r_resp_stb  <= w_resp_stb_nxt;
      r_fin_stb   <= w_fin_stb_nxt;
      r_fout_busy <= w_fout_busy_nxt;
`ifdef FPU_ARB_WDOG_EN
      r_stale     <= w_stale_nxt;
      r_wdog_err  <= w_wdog_err_nxt;
      r_wdog_cnt  <= w_wdog_cnt_nxt;
`endif
    end
  end

  // Data registers need no reset; they are only read behind a strobe
  always_ff @(posedge clk) begin
    if (w_op_load) begin
      r_op_a <= req_a[32*r_grant +: 32];
      r_op_b <= req_b[32*r_grant +: 32];
    end
    if (w_sum_load) begin
      r_sum <= w_sum_src;
    end
  end

endmodule
